// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Frame: start(0), DATA_WIDTH data bits LSB first, odd parity, stop(1).
// rx_in is synchronized by two flops; rx_s is the synchronized line and
// rx_d its one-cycle-delayed copy used for falling-edge detection.
// The FSM returns to IDLE at mid stop bit so a start bit that follows the
// stop bit immediately is still caught.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  uart_clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  rx_busy
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Odd parity fails when data bits plus parity bit hold an even count of ones.
    function automatic logic odd_parity_err(input logic [DATA_WIDTH-1:0] d, input logic p);
        return ~((^d) ^ p);
    endfunction

    logic                  sync1_r;
    logic                  rx_s;
    logic                  rx_d;
    state_t                state_r;
    state_t                state_nxt_s;
    logic [TW-1:0]         tick_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  par_bit_r;

    logic                  fall_s;
    logic                  half_done_s;
    logic                  tick_done_s;
    logic                  tick_clr_s;
    logic                  tick_inc_s;
    logic                  bit_clr_s;
    logic                  shift_en_s;
    logic                  par_en_s;
    logic                  frame_done_s;

    assign fall_s      = rx_d & ~rx_s;
    assign half_done_s = (tick_r == HALF_TICK);
    assign tick_done_s = (tick_r == FULL_TICK);

    // Two-flop synchronizer plus delayed copy for edge detection; idle-high reset.
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            sync1_r <= rx_in;
            rx_s    <= sync1_r;
            rx_d    <= rx_s;
        end
    end

    // FSM state register.
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; unused encodings fall back to IDLE.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (half_done_s) begin
                    state_nxt_s = rx_s ? IDLE : DATA;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (tick_done_s && (bit_cnt_r == LAST_BIT)) begin
                    state_nxt_s = PARITY;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PARITY: begin
                if (tick_done_s) begin
                    state_nxt_s = STOP;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            STOP: begin
                if (tick_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode: datapath strobes for counters, shifter and result capture.
    always_comb begin
        tick_clr_s   = 1'b0;
        tick_inc_s   = 1'b0;
        bit_clr_s    = 1'b0;
        shift_en_s   = 1'b0;
        par_en_s     = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                tick_clr_s = 1'b1;
            end
            START: begin
                if (half_done_s) begin
                    tick_clr_s = 1'b1;
                    bit_clr_s  = ~rx_s;
                end else begin
                    tick_inc_s = 1'b1;
                end
            end
            DATA: begin
                if (tick_done_s) begin
                    tick_clr_s = 1'b1;
                    shift_en_s = 1'b1;
                end else begin
                    tick_inc_s = 1'b1;
                end
            end
            PARITY: begin
                if (tick_done_s) begin
                    tick_clr_s = 1'b1;
                    par_en_s   = 1'b1;
                end else begin
                    tick_inc_s = 1'b1;
                end
            end
            STOP: begin
                if (tick_done_s) begin
                    tick_clr_s   = 1'b1;
                    frame_done_s = 1'b1;
                end else begin
                    tick_inc_s = 1'b1;
                end
            end
            default: begin
                tick_clr_s = 1'b1;
                bit_clr_s  = 1'b1;
            end
        endcase
    end

    // Tick and bit counters, shift register and received parity bit.
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_r    <= '0;
            bit_cnt_r <= '0;
            shift_r   <= '0;
            par_bit_r <= 1'b0;
        end else begin
            if (tick_clr_s) begin
                tick_r <= '0;
            end else if (tick_inc_s) begin
                tick_r <= tick_r + 1'b1;
            end else begin
                tick_r <= tick_r;
            end

            if (bit_clr_s) begin
                bit_cnt_r <= '0;
            end else if (shift_en_s) begin
                bit_cnt_r <= bit_cnt_r + 1'b1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end

            if (shift_en_s) begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    if (bit_cnt_r == BW'(i)) begin
                        shift_r[i] <= rx_s;
                    end
                end
            end

            if (par_en_s) begin
                par_bit_r <= rx_s;
            end
        end
    end

    // Registered outputs: result capture at mid stop bit, one-cycle valid, busy flag.
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            rx_valid <= frame_done_s;
            rx_busy  <= (state_nxt_s != IDLE);
            if (frame_done_s) begin
                rx_data    <= shift_r;
                parity_err <= odd_parity_err(shift_r, par_bit_r);
                frame_err  <= ~rx_s;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a frame-level model of the receiver.
// The model records, for each frame sent, the cycle its rx_valid pulse is due
// and the data/flags it must carry; a per-cycle compare process checks it.
module tb_uart_rx;

    localparam int DW  = 8;
    localparam int OS  = 16;
    // Frame driven from negedge N: mid stop bit sampled on rx_in at posedge
    // N+169 (bit 10 starts at posedge N+161, mid +8), valid visible after
    // 2 more edges -> observed on the negedge where cyc == N+171.
    localparam int LAT = 171;

    logic          uart_clk = 1'b0;
    logic          rst_n    = 1'b0;
    logic          rx_in    = 1'b1;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          parity_err;
    logic          frame_err;
    logic          rx_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        logic [7:0]  data;
        logic        pe;
        logic        fe;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] hold_data = 8'h00;
    logic       hold_pe   = 1'b0;
    logic       hold_fe   = 1'b0;

    uart_rx #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .uart_clk   (uart_clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 uart_clk = ~uart_clk;

    always @(posedge uart_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Parity error when the number of ones over data and parity bit is even.
    function automatic logic model_pe(input logic [7:0] d, input logic p);
        int ones;
        ones = int'(p);
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2) == 0;
    endfunction

    task automatic drive_bits(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge uart_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        exp_t e;
        e.due  = cyc + LAT;
        e.data = d;
        e.pe   = model_pe(d, p);
        e.fe   = ~s;
        expq.push_back(e);
        drive_bits(1'b0, OS);
        for (int i = 0; i < 8; i++) drive_bits(d[i], OS);
        drive_bits(p, OS);
        drive_bits(s, OS);
    endtask

    // Per-cycle comparison of DUT outputs against the frame-level model.
    always @(negedge uart_clk) begin
        if (rst_n) begin
            if (expq.size() > 0 && cyc == expq[0].due) begin
                check("rx_valid_pulse", rx_valid, 1'b1);
                check("rx_data", rx_data, expq[0].data);
                check("parity_err", parity_err, expq[0].pe);
                check("frame_err", frame_err, expq[0].fe);
                hold_data = expq[0].data;
                hold_pe   = expq[0].pe;
                hold_fe   = expq[0].fe;
                void'(expq.pop_front());
            end else begin
                check("rx_valid_idle", rx_valid, 1'b0);
                check("rx_data_hold", rx_data, hold_data);
                check("parity_err_hold", parity_err, hold_pe);
                check("frame_err_hold", frame_err, hold_fe);
            end
        end
    end

    initial begin
        @(negedge uart_clk);
        repeat (3) @(negedge uart_clk);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_rx_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        drive_bits(1'b1, 20);

        // Clean frame 0xA5.
        send_frame(8'hA5, 1'b1, 1'b1);
        drive_bits(1'b1, 10);
        check("a5_data", rx_data, 8'hA5);
        check("a5_pe", parity_err, 1'b0);
        check("a5_fe", frame_err, 1'b0);

        // Wrong parity on 0x3C.
        send_frame(8'h3C, 1'b0, 1'b1);
        drive_bits(1'b1, 10);
        check("3c_data", rx_data, 8'h3C);
        check("3c_pe", parity_err, 1'b1);
        check("3c_fe", frame_err, 1'b0);

        // Stop bit low on 0x81, line then held low: no further frame.
        send_frame(8'h81, 1'b1, 1'b0);
        drive_bits(1'b0, 60);
        check("81_data", rx_data, 8'h81);
        check("81_pe", parity_err, 1'b0);
        check("81_fe", frame_err, 1'b1);
        check("81_busy_low_line", rx_busy, 1'b0);
        drive_bits(1'b1, 20);

        // Glitch of 4 cycles: false start rejected.
        drive_bits(1'b0, 4);
        drive_bits(1'b1, 2);
        check("glitch_busy_start", rx_busy, 1'b1);
        drive_bits(1'b1, 20);
        check("glitch_busy_end", rx_busy, 1'b0);
        check("glitch_data_kept", rx_data, 8'h81);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        drive_bits(1'b1, 10);
        check("b2b_data", rx_data, 8'hFF);
        check("b2b_pe", parity_err, 1'b0);

        // Reset in the middle of data bit 4 (a '1', so the line stays high).
        drive_bits(1'b0, OS);
        for (int i = 0; i < 4; i++) drive_bits(1'b1, OS);
        drive_bits(1'b1, 8);
        check("mid_busy", rx_busy, 1'b1);
        rst_n = 1'b0;
        expq.delete();
        hold_data = 8'h00;
        hold_pe   = 1'b0;
        hold_fe   = 1'b0;
        @(negedge uart_clk);
        check("mrst_rx_data", rx_data, 8'h00);
        check("mrst_rx_valid", rx_valid, 1'b0);
        check("mrst_rx_busy", rx_busy, 1'b0);
        check("mrst_pe", parity_err, 1'b0);
        check("mrst_fe", frame_err, 1'b0);
        repeat (2) @(negedge uart_clk);
        rst_n = 1'b1;
        drive_bits(1'b1, 200);
        check("post_rst_busy", rx_busy, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b1);
        drive_bits(1'b1, 10);
        check("5a_data", rx_data, 8'h5A);
        check("5a_pe", parity_err, 1'b0);
        check("5a_fe", frame_err, 1'b0);

        check("all_pulses_seen", expq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16, uart_clk cycles per bit period; even, >= 4.
REQ-003 uart_clk  input  1  receive clock; frequency = OVERSAMPLE x baud rate.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_in  input  1  serial line, asynchronous to uart_clk, idle high.
REQ-006 rx_data  output  DATA_WIDTH  last received data word, registered.
REQ-007 rx_valid  output  1  one-cycle pulse, frame complete; rx_data and error flags valid.
REQ-008 parity_err  output  1  parity check result of last frame; updated with rx_valid.
REQ-009 frame_err  output  1  stop bit sampled low in last frame; updated with rx_valid.
REQ-010 rx_busy  output  1  high whenever state is not IDLE.

Function
REQ-011 Frame SHALL be: start bit 0, DATA_WIDTH data bits LSB first, one odd-parity bit, one stop bit 1.
REQ-012 Odd parity SHALL hold when XOR of all data bits and the parity bit equals 1; otherwise parity_err = 1.
REQ-013 rx_in SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s plus one delayed copy rx_d.
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP; any unused encoding returns to IDLE next cycle.
REQ-015 IDLE: on falling edge (rx_d = 1, rx_s = 0) -> START, tick counter cleared.
REQ-016 START: at tick OVERSAMPLE/2-1 sample rx_s; 0 -> DATA with tick counter and bit counter cleared; 1 -> IDLE (false start, no rx_valid).
REQ-017 DATA: every OVERSAMPLE ticks (mid-bit) sample rx_s into shift register bit position = bit counter; after DATA_WIDTH samples -> PARITY.
REQ-018 PARITY: sample rx_s after OVERSAMPLE ticks, store as received parity bit -> STOP.
REQ-019 STOP: sample rx_s after OVERSAMPLE ticks (mid stop bit); next cycle rx_valid = 1 for exactly one cycle, rx_data <= shift register, parity_err and frame_err updated; state -> IDLE in that same cycle.
REQ-020 Return to IDLE at mid stop bit SHALL allow a start bit immediately following the stop bit to be caught.
REQ-021 On frame_err, data SHALL still be delivered with rx_valid; no new frame starts until rx_s returns high and falls again (edge rule of REQ-015).
REQ-022 Latency: rx_valid asserts 3 uart_clk cycles after the mid-stop-bit instant on rx_in (2 sync + 1 register).
REQ-023 rx_data, parity_err, frame_err SHALL hold their values between rx_valid pulses.
REQ-024 Tick counter SHALL be ceil(log2(OVERSAMPLE)) bits and wrap to 0 on each mid-bit sample; bit counter SHALL be wide enough for DATA_WIDTH and clear on entry to DATA.
REQ-025 rx_in changes shorter than OVERSAMPLE/2 ticks at start SHALL be rejected per REQ-016.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, synchronizer flops 1, rx_d 1, counters 0, shift register 0, rx_data 0, rx_valid 0, parity_err 0, frame_err 0, rx_busy 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no rx_valid; after release, reception restarts only on a new falling edge.

Verification
REQ-028 Frame 0xA5, parity 1, stop 1 at OVERSAMPLE=16 -> one rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0.
REQ-029 Frame 0x3C with parity bit 0 -> rx_valid, rx_data=0x3C, parity_err=1, frame_err=0.
REQ-030 Frame 0x81, parity 1, stop bit 0 -> rx_valid, rx_data=0x81, frame_err=1; line held low afterwards -> no further rx_valid until high then low.
REQ-031 rx_in low for 4 uart_clk cycles then high -> no rx_valid, rx_busy returns 0, rx_data unchanged.
REQ-032 Back-to-back 0x00 (parity 1) then 0xFF (parity 1), no idle gap -> two rx_valid pulses, 0x00 then 0xFF, no errors.
REQ-033 rst_n pulsed low during bit 4 of a frame -> all outputs 0, no rx_valid; next valid frame 0x5A (parity 1) received correctly.
